// File: rtl/tcm_arb_pkg.sv
// Shared definitions for the TCM external-port arbiter.
// Holds the lock FSM state encoding, the response latency and the lock
// counter width used by tcm_ext_arb.
package tcm_arb_pkg;

  localparam int unsigned RESP_LATENCY = 1;
  localparam int unsigned LOCK_CNT_W   = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tcm_ext_arb.sv
// Two-requester arbiter in front of a single TCM external port.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mN_wr_i/rd_i/addr_i/
//   mN_write_data_i/mN_lock_i    request from requester N (N = 0, 1)
//   mN_accept_o                  request from N taken this cycle
//   mN_ack_o, mN_read_data_o     response strobe and read data to N
//   ext_wr_o/rd_o/addr_o/
//   ext_write_data_o             request presented to the TCM
//   ext_read_data_i              TCM read data, one cycle after accept
//   ext_accept_i                 TCM takes the presented request
//
// Configuration:
//   TCM_EXT_ARB_LOCK_EN  defined: requesters may lock the grant for up to
//                        LOCK_MAX consecutive accepts (IDLE/OWN0/OWN1 FSM).
//                        undefined: mN_lock_i ignored, pure round-robin.
module tcm_ext_arb
  import tcm_arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  m0_wr_i,
  input  logic        m0_rd_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_write_data_i,
  input  logic        m0_lock_i,
  output logic        m0_accept_o,
  output logic        m0_ack_o,
  output logic [31:0] m0_read_data_o,
  input  logic [3:0]  m1_wr_i,
  input  logic        m1_rd_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_write_data_i,
  input  logic        m1_lock_i,
  output logic        m1_accept_o,
  output logic        m1_ack_o,
  output logic [31:0] m1_read_data_o,
  output logic [3:0]  ext_wr_o,
  output logic        ext_rd_o,
  output logic [31:0] ext_addr_o,
  output logic [31:0] ext_write_data_o,
  input  logic [31:0] ext_read_data_i,
  input  logic        ext_accept_i
);

  logic act0, act1;
  logic grant0, grant1, grant_any, accept_any;
  // last_q / hold_owner_q / resp_owner_q: 0 = m0, 1 = m1
  logic last_q, hold_valid_q, hold_owner_q, resp_valid_q, resp_owner_q;
  logic own0, own1;

  assign act0 = m0_rd_i | (m0_wr_i != 4'd0);
  assign act1 = m1_rd_i | (m1_wr_i != 4'd0);

`ifdef TCM_EXT_ARB_LOCK_EN
  arb_state_e            state_q;
  logic [LOCK_CNT_W-1:0] lock_cnt_q;
  logic [LOCK_CNT_W-1:0] lock_cnt_inc;
  logic                  unused_cfg;

  assign own0         = (state_q == ARB_OWN0);
  assign own1         = (state_q == ARB_OWN1);
  assign lock_cnt_inc = lock_cnt_q + LOCK_CNT_W'(1);
  assign unused_cfg   = ^LOCK_CNT_W'(RESP_LATENCY);

  // The counter includes the accept that entered the lock, so the owner gets
  // exactly LOCK_MAX accepts in a row before being forced back to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      lock_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (m0_accept_o && m0_lock_i && (LOCK_MAX > 1)) begin
            state_q    <= ARB_OWN0;
            lock_cnt_q <= LOCK_CNT_W'(1);
          end else if (m1_accept_o && m1_lock_i && (LOCK_MAX > 1)) begin
            state_q    <= ARB_OWN1;
            lock_cnt_q <= LOCK_CNT_W'(1);
          end
        end
        ARB_OWN0: begin
          if (m0_accept_o) begin
            if (!m0_lock_i || (lock_cnt_inc == LOCK_CNT_W'(LOCK_MAX))) begin
              state_q    <= ARB_IDLE;
              lock_cnt_q <= '0;
            end else begin
              lock_cnt_q <= lock_cnt_inc;
            end
          end else if (!m0_lock_i && !act0) begin
            state_q    <= ARB_IDLE;
            lock_cnt_q <= '0;
          end
        end
        ARB_OWN1: begin
          if (m1_accept_o) begin
            if (!m1_lock_i || (lock_cnt_inc == LOCK_CNT_W'(LOCK_MAX))) begin
              state_q    <= ARB_IDLE;
              lock_cnt_q <= '0;
            end else begin
              lock_cnt_q <= lock_cnt_inc;
            end
          end else if (!m1_lock_i && !act1) begin
            state_q    <= ARB_IDLE;
            lock_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= ARB_IDLE;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end
`else
  logic unused_cfg;

  assign own0       = 1'b0;
  assign own1       = 1'b0;
  assign unused_cfg = ^{m0_lock_i, m1_lock_i, LOCK_CNT_W'(LOCK_MAX), LOCK_CNT_W'(RESP_LATENCY)};
`endif

  // Priority: a stalled request keeps its grant, then a lock owner, then
  // round-robin against the last accepted requester. Reset blanks all grants.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_i) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end else if (hold_valid_q) begin
      grant0 = ~hold_owner_q;
      grant1 = hold_owner_q;
    end else if (own0) begin
      grant0 = act0;
    end else if (own1) begin
      grant1 = act1;
    end else if (act0 && act1) begin
      grant0 = last_q;
      grant1 = ~last_q;
    end else begin
      grant0 = act0;
      grant1 = act1;
    end
  end

  assign grant_any   = grant0 | grant1;
  assign accept_any  = grant_any & ext_accept_i;
  assign m0_accept_o = grant0 & ext_accept_i;
  assign m1_accept_o = grant1 & ext_accept_i;

  always_comb begin
    ext_wr_o         = 4'd0;
    ext_rd_o         = 1'b0;
    ext_addr_o       = 32'd0;
    ext_write_data_o = 32'd0;
    if (grant0) begin
      ext_wr_o         = m0_wr_i;
      ext_rd_o         = m0_rd_i;
      ext_addr_o       = m0_addr_i;
      ext_write_data_o = m0_write_data_i;
    end else if (grant1) begin
      ext_wr_o         = m1_wr_i;
      ext_rd_o         = m1_rd_i;
      ext_addr_o       = m1_addr_i;
      ext_write_data_o = m1_write_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q       <= 1'b1;
      hold_valid_q <= 1'b0;
      hold_owner_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
    end else begin
      resp_valid_q <= accept_any;
      resp_owner_q <= grant1;
      if (accept_any) begin
        last_q       <= grant1;
        hold_valid_q <= 1'b0;
      end else if (grant_any) begin
        hold_valid_q <= 1'b1;
        hold_owner_q <= grant1;
      end
    end
  end

  // Gating with rst_i drops a response that is due in the reset cycle.
  assign m0_ack_o       = resp_valid_q & ~resp_owner_q & ~rst_i;
  assign m1_ack_o       = resp_valid_q & resp_owner_q & ~rst_i;
  assign m0_read_data_o = m0_ack_o ? ext_read_data_i : 32'd0;
  assign m1_read_data_o = m1_ack_o ? ext_read_data_i : 32'd0;

endmodule

// File: tb/tb_tcm_ext_arb.sv
module tb_tcm_ext_arb;

  localparam int unsigned LockMax = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  wr    [2];
  logic        rd    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        lock  [2];
  logic [31:0] ext_rdata;
  logic        ext_acc;

  logic        m0_accept, m1_accept, m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  ext_wr;
  logic        ext_rd;
  logic [31:0] ext_addr, ext_wdata;

  tcm_ext_arb #(
    .LOCK_MAX(LockMax)
  ) u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .m0_wr_i         (wr[0]),
    .m0_rd_i         (rd[0]),
    .m0_addr_i       (addr[0]),
    .m0_write_data_i (wdata[0]),
    .m0_lock_i       (lock[0]),
    .m0_accept_o     (m0_accept),
    .m0_ack_o        (m0_ack),
    .m0_read_data_o  (m0_rdata),
    .m1_wr_i         (wr[1]),
    .m1_rd_i         (rd[1]),
    .m1_addr_i       (addr[1]),
    .m1_write_data_i (wdata[1]),
    .m1_lock_i       (lock[1]),
    .m1_accept_o     (m1_accept),
    .m1_ack_o        (m1_ack),
    .m1_read_data_o  (m1_rdata),
    .ext_wr_o        (ext_wr),
    .ext_rd_o        (ext_rd),
    .ext_addr_o      (ext_addr),
    .ext_write_data_o(ext_wdata),
    .ext_read_data_i (ext_rdata),
    .ext_accept_i    (ext_acc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: requester indices as ints, -1 meaning "nobody".
  int m_last     = 1;   // requester served by the last accepted transfer
  int m_hold     = -1;  // requester whose stalled request keeps the port
  int m_resp     = -1;  // requester owed an ack this cycle
  int m_lock_own = -1;  // lock owner
  int m_lock_cnt = 0;   // accepts made under the current lock
  int exp_g      = -1;
  bit exp_acc [2];

  function automatic bit active(input int n);
    return rd[n] || (wr[n] != 4'd0);
  endfunction

  function automatic int pick();
    if (rst) return -1;
    if (m_hold >= 0) return m_hold;
    if (m_lock_own >= 0) return active(m_lock_own) ? m_lock_own : -1;
    if (active(0) && active(1)) return 1 - m_last;
    if (active(0)) return 0;
    if (active(1)) return 1;
    return -1;
  endfunction

  // Check every output against the model at the falling edge.
  task automatic sample();
    int g;
    logic [3:0]  e_wr;
    logic        e_rd;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    g = pick();
    exp_g = g;
    e_wr = 4'd0; e_rd = 1'b0; e_addr = 32'd0; e_wd = 32'd0;
    if (g >= 0) begin
      e_wr = wr[g]; e_rd = rd[g]; e_addr = addr[g]; e_wd = wdata[g];
    end
    exp_acc[0] = (g == 0) && ext_acc;
    exp_acc[1] = (g == 1) && ext_acc;
    check("ext_wr", 32'(ext_wr), 32'(e_wr));
    check("ext_rd", 32'(ext_rd), 32'(e_rd));
    check("ext_addr", ext_addr, e_addr);
    check("ext_wdata", ext_wdata, e_wd);
    check("m0_accept", 32'(m0_accept), 32'(exp_acc[0]));
    check("m1_accept", 32'(m1_accept), 32'(exp_acc[1]));
    check("m0_ack", 32'(m0_ack), 32'((m_resp == 0) && !rst));
    check("m1_ack", 32'(m1_ack), 32'((m_resp == 1) && !rst));
    check("m0_rdata", m0_rdata, ((m_resp == 0) && !rst) ? ext_rdata : 32'd0);
    check("m1_rdata", m1_rdata, ((m_resp == 1) && !rst) ? ext_rdata : 32'd0);
  endtask

  // Advance the model across the rising edge; inputs may change afterwards.
  task automatic advance();
    int g;
    bit acc;
    @(posedge clk);
    g = exp_g;
    if (rst) begin
      m_last = 1; m_hold = -1; m_resp = -1; m_lock_own = -1; m_lock_cnt = 0;
    end else begin
      acc    = (g >= 0) && ext_acc;
      m_resp = acc ? g : -1;
      if (acc) begin
        m_last = g;
        m_hold = -1;
      end else if (g >= 0) begin
        m_hold = g;
      end
`ifdef TCM_EXT_ARB_LOCK_EN
      if (m_lock_own < 0) begin
        if (acc && lock[g] && (LockMax > 1)) begin
          m_lock_own = g;
          m_lock_cnt = 1;
        end
      end else if (acc) begin
        m_lock_cnt++;
        if (!lock[g] || m_lock_cnt >= LockMax) begin
          m_lock_own = -1;
          m_lock_cnt = 0;
        end
      end else if (!lock[m_lock_own] && !active(m_lock_own)) begin
        m_lock_own = -1;
        m_lock_cnt = 0;
      end
`endif
    end
    #1;
  endtask

  task automatic idle(input int n);
    wr[n] = 4'd0; rd[n] = 1'b0; addr[n] = 32'd0; wdata[n] = 32'd0; lock[n] = 1'b0;
  endtask

  task automatic req_rd(input int n, input logic [31:0] a);
    wr[n] = 4'd0; rd[n] = 1'b1; addr[n] = a; wdata[n] = 32'd0; lock[n] = 1'b0;
  endtask

  task automatic req_wr(input int n, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d);
    wr[n] = s; rd[n] = 1'b0; addr[n] = a; wdata[n] = d; lock[n] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
  endtask

  task automatic req_rand(input int n);
    if ($urandom_range(0, 1) == 0) begin
      idle(n);
    end else begin
      if ($urandom_range(0, 1) == 0) req_rd(n, $urandom);
      else req_wr(n, 4'($urandom_range(1, 15)), $urandom, $urandom);
      lock[n] = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    rst = 1'b1; ext_acc = 1'b0; ext_rdata = 32'd0;
    idle(0); idle(1);
    #1;
    sample();
    check("rst_ext_rd", 32'(ext_rd), 32'd0);
    check("rst_m0_ack", 32'(m0_ack), 32'd0);
    advance();
    do_reset();

    // m0 reads alone: same-cycle grant, ack next cycle.
    req_rd(0, 32'h0000_2000); ext_acc = 1'b1;
    sample();
    check("rd_ext_rd", 32'(ext_rd), 32'd1);
    check("rd_ext_addr", ext_addr, 32'h0000_2000);
    check("rd_m0_accept", 32'(m0_accept), 32'd1);
    advance();
    idle(0); ext_rdata = 32'h1234_5678;
    sample();
    check("rd_m0_ack", 32'(m0_ack), 32'd1);
    check("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    advance();

    // Both active continuously: strict alternation starting with m0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req_rd(0, 32'h100 + 32'(i)); req_rd(1, 32'h200 + 32'(i));
      ext_rdata = $urandom;
      sample();
      check("rr_m0_accept", 32'(m0_accept), 32'(i % 2 == 0));
      check("rr_m1_accept", 32'(m1_accept), 32'(i % 2 == 1));
      if (i > 0) check("rr_m0_ack", 32'(m0_ack), 32'(i % 2 == 1));
      if (i > 0) check("rr_m1_ack", 32'(m1_ack), 32'(i % 2 == 0));
      advance();
    end
    idle(0); idle(1);
    sample();
    advance();

    // Stalled m1 keeps the grant while m0 arrives.
    idle(0); req_rd(1, 32'h0000_3000); ext_acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) req_rd(0, 32'h0000_4000);
      if (i == 3) ext_acc = 1'b1;
      sample();
      check("hold_ext_addr", ext_addr, 32'h0000_3000);
      check("hold_m1_accept", 32'(m1_accept), 32'(i == 3));
      check("hold_m0_accept", 32'(m0_accept), 32'd0);
      advance();
    end
    idle(1);
    sample();
    check("hold_then_m0", ext_addr, 32'h0000_4000);
    check("hold_then_m0_acc", 32'(m0_accept), 32'd1);
    advance();
    idle(0);

    // m1 partial write.
    req_wr(1, 4'b0011, 32'h0000_2004, 32'hDEAD_BEEF); ext_acc = 1'b1;
    sample();
    check("wr_ext_wr", 32'(ext_wr), 32'd3);
    check("wr_ext_addr", ext_addr, 32'h0000_2004);
    check("wr_ext_wdata", ext_wdata, 32'hDEAD_BEEF);
    check("wr_m1_accept", 32'(m1_accept), 32'd1);
    advance();
    idle(1); ext_rdata = 32'h5555_AAAA;
    sample();
    check("wr_m1_ack", 32'(m1_ack), 32'd1);
    advance();

    // Reset in the response cycle drops the ack and blanks the port.
    req_rd(0, 32'h0000_2008);
    sample();
    advance();
    idle(0); req_rd(1, 32'h0000_200C); rst = 1'b1;
    sample();
    check("rstresp_m0_ack", 32'(m0_ack), 32'd0);
    check("rstresp_ext_rd", 32'(ext_rd), 32'd0);
    check("rstresp_ext_addr", ext_addr, 32'd0);
    check("rstresp_m1_accept", 32'(m1_accept), 32'd0);
    advance();
    rst = 1'b0; idle(1);
    sample();
    check("rstresp_no_ack", 32'(m0_ack | m1_ack), 32'd0);
    advance();

`ifdef TCM_EXT_ARB_LOCK_EN
    // m0 holds lock against a waiting m1: LockMax accepts, then m1.
    do_reset();
    ext_acc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_rd(0, 32'h500 + 32'(i)); lock[0] = 1'b1;
      if (i == 0 || exp_acc[1]) req_rd(1, 32'h600 + 32'(i));
      sample();
      check("lock_m0_accept", 32'(m0_accept), 32'(i != LockMax));
      check("lock_m1_accept", 32'(m1_accept), 32'(i == LockMax));
      advance();
    end
    idle(0); idle(1);
    sample();
    advance();
`endif

    // Randomized traffic against the model.
    exp_acc[0] = 1'b1; exp_acc[1] = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      ext_acc   = ($urandom_range(0, 9) < 7);
      ext_rdata = $urandom;
      for (int n = 0; n < 2; n++) begin
        if (exp_acc[n] || !active(n)) req_rand(n);
      end
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
